// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the serial instruction-memory boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_loader_pkg;

    // Width of one CPU instruction word; also the instruction-memory data width.
    localparam int INST_W = 32;

    // 50 MHz board clock / 115200 baud.
    localparam int UART_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        SUM   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loader_state_e;

endpackage

// File: rtl/inst_loader_if.sv
// Instruction-memory write port shared by the boot loader and the fetch-side memory.
// Latency: n/a (wires only).
// Backpressure: none; the memory accepts a write in the cycle imem_we is high.
// Ports: imem_we (1-cycle strobe), imem_addr (word address), imem_wdata (instruction word).
interface inst_loader_if #(
    parameter int ADDR_W = 8
);
    import inst_loader_pkg::*;

    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_wdata;

    modport master (output imem_we, imem_addr, imem_wdata);
    modport slave  (input  imem_we, imem_addr, imem_wdata);

endinterface

// File: rtl/inst_loader_uart_rx_byte.sv
// UART 8N1 byte receiver with 2-flop synchroniser and mid-bit sampling.
// Latency: rx_valid/frame_err pulse at the middle of the stop bit (+3 cycles sync/edge).
// Backpressure: none; consumer must take the byte in the pulse cycle.
// Ports: clk, rst (async high), rx (idle high) -> rx_valid, rx_data[7:0], frame_err.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] U_IDLE  = 2'd0;
    localparam logic [1:0] U_START = 2'd1;
    localparam logic [1:0] U_DATA  = 2'd2;
    localparam logic [1:0] U_STOP  = 2'd3;

    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          vld_q, vld_d;
    logic          ferr_q, ferr_d;

    // Synchroniser presets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        vld_d  = 1'b0;
        ferr_d = 1'b0;
        case (st_q)
            U_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    st_d  = U_START;
                    cnt_d = '0;
                end
            end
            U_START: begin
                // Re-check at half bit: a short low glitch falls back to idle silently.
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = rx_s2_q ? U_IDLE : U_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            U_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    sh_d  = {rx_s2_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        st_d = U_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // Return to idle at mid-stop so a back-to-back start edge is caught.
                if (cnt_q == LAST_CNT) begin
                    st_d   = U_IDLE;
                    vld_d  = rx_s2_q;
                    ferr_d = !rx_s2_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= U_IDLE;
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            vld_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            vld_q  <= vld_d;
            ferr_q <= ferr_d;
        end
    end

    assign rx_valid  = vld_q;
    assign rx_data   = sh_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/inst_loader.sv
// Boot loader: UART frame (N, N*4 bytes, XOR) -> sequential instruction-memory writes, then cpu_run.
// Latency: imem_we pulses 1 cycle after the rx_valid of each word's 4th byte.
// Backpressure: none; every received byte is consumed in its rx_valid cycle.
// Ports: clk, rst (async high), rx; imem (write-port master); cpu_run, load_err, words_loaded.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int ADDR_W       = 8,
    parameter int WORD_BYTES   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    inst_loader_if.master       imem,
    output logic                cpu_run,
    output logic                load_err,
    output logic [ADDR_W:0]     words_loaded
);
    localparam int BI_W = $clog2(WORD_BYTES);
    localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(WORD_BYTES - 1);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_DATA  = DATA;
    localparam logic [2:0] S_WRITE = WRITE;
    localparam logic [2:0] S_SUM   = SUM;
    localparam logic [2:0] S_DONE  = DONE;
    localparam logic [2:0] S_ERR   = ERR;

    logic       rx_valid, frame_err;
    logic [7:0] rx_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .frame_err (frame_err)
    );

    logic [2:0]        state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [BI_W-1:0]   idx_q, idx_d;
    logic [INST_W-1:0] word_q, word_d;
    logic [7:0]        xor_q, xor_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              run_q, err_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        word_d  = word_q;
        xor_d   = xor_q;
        words_d = words_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (frame_err) begin
                    state_d = S_ERR;
                end else if (rx_valid) begin
                    n_d     = rx_data;
                    idx_d   = '0;
                    xor_d   = '0;
                    state_d = (rx_data == 8'd0) ? S_SUM : S_DATA;
                end
            end
            S_DATA: begin
                if (frame_err) begin
                    state_d = S_ERR;
                end else if (rx_valid) begin
                    word_d[8*idx_q +: 8] = rx_data;
                    xor_d = xor_q ^ rx_data;
                    idx_d = idx_q + BI_W'(1);
                    if (idx_q == LAST_BYTE) begin
                        idx_d = '0;
                        // Memory already full: refuse to wrap onto address 0.
                        if (words_q[ADDR_W]) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_WRITE;
                            addr_d  = words_q[ADDR_W-1:0];
                        end
                    end
                end
            end
            S_WRITE: begin
                words_d = words_q + 1'b1;
                if (frame_err) begin
                    state_d = S_ERR;
                end else if (9'(words_q) + 9'd1 == {1'b0, n_q}) begin
                    state_d = S_SUM;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_SUM: begin
                if (frame_err) begin
                    state_d = S_ERR;
                end else if (rx_valid) begin
                    state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            xor_q   <= '0;
            words_q <= '0;
            addr_q  <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            xor_q   <= xor_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            // Flags are flops, not state decodes, because cpu_run drives a clock gate.
            run_q   <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
        end
    end

    assign imem.imem_we    = (state_q == S_WRITE);
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = word_q;
    assign cpu_run         = run_q;
    assign load_err        = err_q;
    assign words_loaded    = words_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: frames sent over a fast UART, checked against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_inst_loader;
    localparam int CPB    = 16;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic              cpu_run, load_err;
    logic [ADDR_W:0]   words_loaded;

    inst_loader_if #(.ADDR_W(ADDR_W)) imem_bus ();

    inst_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .WORD_BYTES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .imem         (imem_bus),
        .cpu_run      (cpu_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Frame-level model: the byte list being sent and what it must produce.
    logic [7:0]  frm[$];
    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_run, exp_err;
    int          exp_words;
    logic [31:0] mem [256];

    task automatic model_frame(input int nsend, input int bad_idx);
        int n;
        logic [7:0] x;
        bit term;
        exp_run = 0; exp_err = 0; exp_words = 0; term = 0; n = 0; x = 8'h00;
        for (int i = 0; i < nsend && !term; i++) begin
            if (i == bad_idx) begin
                exp_err = 1; term = 1;
            end else if (i == 0) begin
                n = int'(frm[0]);
            end else if (i - 1 < 4 * n) begin
                x ^= frm[i];
                if ((i - 1) % 4 == 3) begin
                    int k;
                    k = (i - 1) / 4;
                    exp_addr.push_back(k[7:0]);
                    exp_data.push_back({frm[4*k+4], frm[4*k+3], frm[4*k+2], frm[4*k+1]});
                    exp_words++;
                end
            end else begin
                if (frm[i] == x) exp_run = 1; else exp_err = 1;
                term = 1;
            end
        end
    endtask

    // Per-cycle compare: every write against the model queue, progress counter against writes seen.
    int          wr_seen = 0;
    logic [7:0]  ea;
    logic [31:0] ed;
    always @(negedge clk) begin
        if (rst) begin
            wr_seen = 0;
        end else begin
            chk("words_loaded_track", 64'(words_loaded), 64'(wr_seen));
            chk("run_err_exclusive", 64'(cpu_run & load_err), 64'd0);
            if (imem_bus.imem_we) begin
                chk("write_expected", 64'(exp_addr.size() > 0), 64'd1);
                if (exp_addr.size() > 0) begin
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    chk("write_addr", 64'(imem_bus.imem_addr), 64'(ea));
                    chk("write_data", 64'(imem_bus.imem_wdata), 64'(ed));
                end
                mem[imem_bus.imem_addr] = imem_bus.imem_wdata;
                wr_seen++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = ~bad_stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic run_frame(input int nsend, input int bad_idx, input int gap_bits);
        model_frame(nsend, bad_idx);
        for (int i = 0; i < nsend; i++) begin
            send_byte(frm[i], i == bad_idx);
            repeat (gap_bits * CPB) @(negedge clk);
        end
    endtask

    task automatic check_end(input string nm);
        repeat (2 * CPB) @(negedge clk);
        chk({nm, "_cpu_run"}, 64'(cpu_run), 64'(exp_run));
        chk({nm, "_load_err"}, 64'(load_err), 64'(exp_err));
        chk({nm, "_words"}, 64'(words_loaded), 64'(exp_words));
        chk({nm, "_pending_writes"}, 64'(exp_addr.size()), 64'd0);
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cpu_run", 64'(cpu_run), 64'd0);
        chk("rst_load_err", 64'(load_err), 64'd0);
        chk("rst_words", 64'(words_loaded), 64'd0);
        chk("rst_we", 64'(imem_bus.imem_we), 64'd0);
        chk("rst_addr", 64'(imem_bus.imem_addr), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two words back-to-back; XOR of the eight data bytes is 0x66.
        frm = '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h66};
        run_frame(frm.size(), -1, 0);
        check_end("two_words");
        chk("two_words_mem0", 64'(mem[0]), 64'h11223344);
        chk("two_words_mem1", 64'(mem[1]), 64'hDEADBEEF);
        chk("two_words_run_lit", 64'(cpu_run), 64'd1);
        chk("two_words_addr_hold", 64'(imem_bus.imem_addr), 64'd1);

        // Wrong checksum after one word.
        do_reset();
        frm = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(frm.size(), -1, 1);
        check_end("bad_sum");
        chk("bad_sum_mem0", 64'(mem[0]), 64'h00000001);
        chk("bad_sum_err_lit", 64'(load_err), 64'd1);

        // Empty program.
        do_reset();
        frm = '{8'h00, 8'h00};
        run_frame(frm.size(), -1, 1);
        check_end("empty");
        chk("empty_run_lit", 64'(cpu_run), 64'd1);

        // Framing error on the second data byte; later bytes must be ignored.
        do_reset();
        frm = '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55, 8'h66};
        run_frame(frm.size(), 2, 1);
        check_end("frame_err");
        chk("frame_err_words_lit", 64'(words_loaded), 64'd0);

        // Short glitch on the idle line, then a normal single-word load.
        do_reset();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        frm = '{8'h01, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hC9};
        run_frame(frm.size(), -1, 1);
        check_end("glitch");
        chk("glitch_mem0", 64'(mem[0]), 64'hCAFEF00D);

        // Reset partway through the third word of a four-word load.
        do_reset();
        frm = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hAA, 8'hBB};
        run_frame(frm.size(), -1, 0);
        chk("pre_rst_words", 64'(words_loaded), 64'd2);
        chk("pre_rst_mem1", 64'(mem[1]), 64'h40302010);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_words", 64'(words_loaded), 64'd0);
        chk("async_rst_addr", 64'(imem_bus.imem_addr), 64'd0);
        chk("async_rst_we", 64'(imem_bus.imem_we), 64'd0);
        chk("async_rst_err", 64'(load_err), 64'd0);
        chk("async_rst_pending", 64'(exp_addr.size()), 64'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        frm = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        run_frame(frm.size(), -1, 0);
        check_end("reload");
        chk("reload_mem0", 64'(mem[0]), 64'h12345678);
        chk("reload_mem1_kept", 64'(mem[1]), 64'h40302010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
